// File: rtl/axi_rom_slave.sv
// Read-only AXI slave in front of the boot ROM macro: turns each INCR read burst
// into one single-word ROM access per beat, with one transaction in flight.
module axi_rom_slave #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ROM_AW = 12
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [IDS_W-1:0]  ARID_S0,
    input  logic [ADDR_W-1:0] ARADDR_S0,
    input  logic [3:0]        ARLEN_S0,
    input  logic [2:0]        ARSIZE_S0,
    input  logic [1:0]        ARBURST_S0,
    input  logic              ARVALID_S0,
    output logic              ARREADY_S0,
    output logic [IDS_W-1:0]  RID_S0,
    output logic [DATA_W-1:0] RDATA_S0,
    output logic [1:0]        RRESP_S0,
    output logic              RLAST_S0,
    output logic              RVALID_S0,
    input  logic              RREADY_S0,
    output logic              ROM_enable,
    output logic              ROM_read,
    output logic [ROM_AW-1:0] ROM_address,
    input  logic [DATA_W-1:0] ROM_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDS_W-1:0]   id_q, id_d;
    logic [3:0]         len_q, len_d;
    logic [3:0]         beat_q, beat_d;
    logic [ROM_AW-1:0]  addr_q, addr_d;
    logic               arready_q, arready_d;
    logic               rom_en_q, rom_en_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic [IDS_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    // Every request is served as a 32-bit aligned INCR, so these bits never matter.
    logic unused_s;
    assign unused_s = ^{ARSIZE_S0, ARBURST_S0, ARADDR_S0[ADDR_W-1:ROM_AW+2], ARADDR_S0[1:0]};

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ARVALID_S0 && arready_q) begin
                    id_d    = ARID_S0;
                    len_d   = ARLEN_S0;
                    addr_d  = ARADDR_S0[ROM_AW+1:2];
                    beat_d  = 4'd0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_DATA;
            ST_DATA: begin
                if (RREADY_S0) begin
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = addr_q + {{(ROM_AW-1){1'b0}}, 1'b1};
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        arready_d  = (state_d == ST_IDLE);
        rom_en_d   = (state_d == ST_FETCH);
        rom_addr_d = rom_en_d ? addr_d : rom_addr_q;
        rvalid_d   = (state_d == ST_DATA);
        rlast_d    = (state_d == ST_DATA) && (beat_d == len_d);
        rid_d      = (state_d == ST_DATA) ? id_d : {IDS_W{1'b0}};
        if (state_q == ST_WAIT) begin
            rdata_d = ROM_out;
        end else if (state_d == ST_DATA) begin
            rdata_d = rdata_q;
        end else begin
            rdata_d = {DATA_W{1'b0}};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            id_q       <= {IDS_W{1'b0}};
            len_q      <= 4'd0;
            beat_q     <= 4'd0;
            addr_q     <= {ROM_AW{1'b0}};
            arready_q  <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= {ROM_AW{1'b0}};
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= {IDS_W{1'b0}};
            rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            arready_q  <= arready_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ARREADY_S0  = arready_q;
    assign RVALID_S0   = rvalid_q;
    assign RLAST_S0    = rlast_q;
    assign RID_S0      = rid_q;
    assign RDATA_S0    = rdata_q;
    assign RRESP_S0    = 2'b00;
    assign ROM_enable  = rom_en_q;
    assign ROM_read    = rom_en_q;
    assign ROM_address = rom_addr_q;

endmodule

// File: tb/tb_axi_rom_slave.sv
// Directed bench for axi_rom_slave: a per-cycle vector table for the basic reads
// plus hand-written sequences for stalls, wrap, mid-burst reset and held AR.
module tb_axi_rom_slave;

    logic        clk;
    logic        aresetn;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rom_enable;
    logic        rom_read;
    logic [11:0] rom_address;
    logic [31:0] rom_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rstn;
        logic        arvalid;
        logic [7:0]  arid;
        logic [31:0] araddr;
        logic [3:0]  arlen;
        logic        rready;
        logic        e_arready;
        logic        e_rvalid;
        logic        e_rlast;
        logic [7:0]  e_rid;
        logic [31:0] e_rdata;
        logic        e_rom_en;
        logic [11:0] e_rom_addr;
    } vec_t;

    vec_t vecs[$];

    axi_rom_slave #(
        .IDS_W(8), .ADDR_W(32), .DATA_W(32), .ROM_AW(12)
    ) dut (
        .ACLK(clk),
        .ARESETn(aresetn),
        .ARID_S0(arid),
        .ARADDR_S0(araddr),
        .ARLEN_S0(arlen),
        .ARSIZE_S0(arsize),
        .ARBURST_S0(arburst),
        .ARVALID_S0(arvalid),
        .ARREADY_S0(arready),
        .RID_S0(rid),
        .RDATA_S0(rdata),
        .RRESP_S0(rresp),
        .RLAST_S0(rlast),
        .RVALID_S0(rvalid),
        .RREADY_S0(rready),
        .ROM_enable(rom_enable),
        .ROM_read(rom_read),
        .ROM_address(rom_address),
        .ROM_out(rom_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hB0, a ^ 12'hA5A, a};
    endfunction

    // ROM macro model: data appears the cycle after an enable+read cycle, junk otherwise.
    always @(posedge clk) begin
        rom_out <= (rom_enable && rom_read) ? rom_word(rom_address) : 32'hDEAD_BEEF;
    end

    function automatic void add_vec(input logic rstn, input logic av, input logic [7:0] id,
                                    input logic [31:0] ad, input logic [3:0] ln, input logic rr,
                                    input logic e_ar, input logic e_rv, input logic e_rl,
                                    input logic [7:0] e_id, input logic [31:0] e_rd,
                                    input logic e_en, input logic [11:0] e_ra);
        vec_t v;
        v.rstn = rstn; v.arvalid = av; v.arid = id; v.araddr = ad; v.arlen = ln; v.rready = rr;
        v.e_arready = e_ar; v.e_rvalid = e_rv; v.e_rlast = e_rl; v.e_rid = e_id;
        v.e_rdata = e_rd; v.e_rom_en = e_en; v.e_rom_addr = e_ra;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic e_ar, input logic e_rv, input logic e_rl,
                         input logic [7:0] e_id, input logic [31:0] e_rd,
                         input logic e_en, input logic [11:0] e_ra);
        n_cmp++;
        if ({arready, rvalid, rlast, rid, rdata, rresp, rom_enable, rom_read, rom_address} !==
            {e_ar, e_rv, e_rl, e_id, e_rd, 2'b00, e_en, e_en, e_ra}) begin
            n_bad++;
            $display("FAIL %s: got arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b rom_en=%b rom_rd=%b rom_addr=%h; want arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=00 rom_en=%b rom_rd=%b rom_addr=%h",
                     name, arready, rvalid, rlast, rid, rdata, rresp, rom_enable, rom_read, rom_address,
                     e_ar, e_rv, e_rl, e_id, e_rd, e_en, e_en, e_ra);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle(input string n, input logic [11:0] ra);
        step();
        check(n, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, ra);
    endtask

    task automatic exp_fetch(input string n, input logic [11:0] a);
        step();
        check(n, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, a);
    endtask

    task automatic exp_wait(input string n, input logic [11:0] a);
        step();
        check(n, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, a);
    endtask

    task automatic exp_data(input string n, input logic [11:0] a, input logic [7:0] id, input logic last);
        step();
        check(n, 1'b0, 1'b1, last, id, rom_word(a), 1'b0, a);
    endtask

    task automatic drive_ar(input logic [7:0] id, input logic [31:0] ad, input logic [3:0] ln);
        arvalid = 1'b1;
        arid    = id;
        araddr  = ad;
        arlen   = ln;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0; arvalid = 1'b0; arid = 8'h00; araddr = 32'h0; arlen = 4'd0;
        arsize  = 3'b010; arburst = 2'b01; rready = 1'b0;

        // Reset, then a single-beat read of word 4 with two stall cycles.
        add_vec(1'b0, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd0);
        add_vec(1'b0, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd0);
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd0);
        add_vec(1'b1, 1'b1, 8'h15, 32'h10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 12'd4);
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd4);
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, rom_word(12'd4), 1'b0, 12'd4);
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, rom_word(12'd4), 1'b0, 12'd4);
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd4);
        // Four-beat burst from word 0 with RREADY held high: FETCH/WAIT/DATA per beat.
        add_vec(1'b1, 1'b1, 8'h03, 32'h0,  4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 12'd0);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                add_vec(1'b1, 1'b0, 8'h00, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 12'(b));
            end
            add_vec(1'b1, 1'b0, 8'h00, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'(b));
            add_vec(1'b1, 1'b0, 8'h00, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1, (b == 3), 8'h03,
                    rom_word(12'(b)), 1'b0, 12'(b));
        end
        add_vec(1'b1, 1'b0, 8'h00, 32'h0,  4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd3);

        foreach (vecs[i]) begin
            aresetn = vecs[i].rstn;
            arvalid = vecs[i].arvalid;
            arid    = vecs[i].arid;
            araddr  = vecs[i].araddr;
            arlen   = vecs[i].arlen;
            rready  = vecs[i].rready;
            step();
            check($sformatf("vec%0d", i), vecs[i].e_arready, vecs[i].e_rvalid, vecs[i].e_rlast,
                  vecs[i].e_rid, vecs[i].e_rdata, vecs[i].e_rom_en, vecs[i].e_rom_addr);
        end
        arvalid = 1'b0;

        // Backpressure: three beats from word 16, beat 1 stalled for five cycles.
        rready = 1'b1;
        drive_ar(8'h07, 32'h40, 4'd2);
        exp_fetch("bp_fetch0", 12'd16);
        arvalid = 1'b0;
        exp_wait("bp_wait0", 12'd16);
        exp_data("bp_data0", 12'd16, 8'h07, 1'b0);
        exp_fetch("bp_fetch1", 12'd17);
        exp_wait("bp_wait1", 12'd17);
        rready = 1'b0;
        exp_data("bp_data1", 12'd17, 8'h07, 1'b0);
        for (int s = 0; s < 4; s++) begin
            exp_data($sformatf("bp_stall%0d", s), 12'd17, 8'h07, 1'b0);
        end
        rready = 1'b1;
        exp_fetch("bp_fetch2", 12'd18);
        exp_wait("bp_wait2", 12'd18);
        exp_data("bp_data2", 12'd18, 8'h07, 1'b1);
        exp_idle("bp_idle", 12'd18);

        // Address wrap from the top ROM word back to word 0.
        drive_ar(8'h0A, 32'h3FFC, 4'd1);
        exp_fetch("wrap_fetch0", 12'd4095);
        arvalid = 1'b0;
        exp_wait("wrap_wait0", 12'd4095);
        exp_data("wrap_data0", 12'd4095, 8'h0A, 1'b0);
        exp_fetch("wrap_fetch1", 12'd0);
        exp_wait("wrap_wait1", 12'd0);
        exp_data("wrap_data1", 12'd0, 8'h0A, 1'b1);
        exp_idle("wrap_idle", 12'd0);

        // Reset while beat 2 of an eight-beat burst is on the R channel.
        drive_ar(8'h31, 32'h100, 4'd7);
        exp_fetch("rst_fetch0", 12'd64);
        arvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
                exp_fetch($sformatf("rst_fetch%0d", b), 12'(64 + b));
            end
            exp_wait($sformatf("rst_wait%0d", b), 12'(64 + b));
            exp_data($sformatf("rst_data%0d", b), 12'(64 + b), 8'h31, 1'b0);
        end
        aresetn = 1'b0;
        step();
        check("rst_asserted", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 12'd0);
        aresetn = 1'b1;
        exp_idle("rst_released", 12'd0);
        drive_ar(8'h44, 32'h20, 4'd0);
        exp_fetch("rst_new_fetch", 12'd8);
        arvalid = 1'b0;
        exp_wait("rst_new_wait", 12'd8);
        exp_data("rst_new_data", 12'd8, 8'h44, 1'b1);
        exp_idle("rst_new_idle", 12'd8);

        // A second AR held during a stalled DATA beat is taken only once back in IDLE.
        rready = 1'b0;
        drive_ar(8'h11, 32'h8, 4'd0);
        exp_fetch("hold_fetch_a", 12'd2);
        drive_ar(8'h22, 32'hC, 4'd0);
        exp_wait("hold_wait_a", 12'd2);
        exp_data("hold_data_a", 12'd2, 8'h11, 1'b1);
        for (int s = 0; s < 3; s++) begin
            exp_data($sformatf("hold_stall%0d", s), 12'd2, 8'h11, 1'b1);
        end
        rready = 1'b1;
        exp_idle("hold_idle", 12'd2);
        exp_fetch("hold_fetch_b", 12'd3);
        arvalid = 1'b0;
        exp_wait("hold_wait_b", 12'd3);
        exp_data("hold_data_b", 12'd3, 8'h22, 1'b1);
        exp_idle("hold_idle_b", 12'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
